// File: rtl/dac_spi_tx.sv
// SPI frame transmitter for one DAC channel: latches a parallel frame on a
// valid/ready handshake, shifts it MSB first on SYNC/SCLK/SDI, then holds SYNC high for a gap.
module dac_spi_tx #(
  parameter int FRAME_WIDTH = 24,
  parameter int CLK_DIV     = 10,
  parameter int WAIT_CYCLES = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [FRAME_WIDTH-1:0] frame_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic                   done_o,
  output logic                   sync_o,
  output logic                   sclk_o,
  output logic                   sdi_o
);

  // state | meaning
  // IDLE  | waiting for a frame, ready_o high
  // HIGH  | SCLK high half-period, SDI holds the current bit
  // LOW   | SCLK low half-period, DAC has sampled on the falling edge
  // GAP   | SYNC held high after a frame before ready_o returns
  typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
  localparam int GW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_FIRST = BW'(FRAME_WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t                 state, state_d;
  logic [FRAME_WIDTH-1:0] shreg, shreg_d;
  logic [DW-1:0]          div_cnt, div_d;
  logic [BW-1:0]          bit_cnt, bit_d;
  logic [GW-1:0]          gap_cnt, gap_d;
  logic                   ready_d, done_d, sync_d, sclk_d, sdi_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state   <= IDLE;
      shreg   <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      ready_o <= 1'b1;
      done_o  <= 1'b0;
      sync_o  <= 1'b1;
      sclk_o  <= 1'b1;
      sdi_o   <= 1'b0;
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      div_cnt <= div_d;
      bit_cnt <= bit_d;
      gap_cnt <= gap_d;
      ready_o <= ready_d;
      done_o  <= done_d;
      sync_o  <= sync_d;
      sclk_o  <= sclk_d;
      sdi_o   <= sdi_d;
    end
  end

  always_comb begin
    state_d = state;
    shreg_d = shreg;
    div_d   = div_cnt;
    bit_d   = bit_cnt;
    gap_d   = gap_cnt;
    ready_d = ready_o;
    done_d  = 1'b0;
    sync_d  = sync_o;
    sclk_d  = sclk_o;
    sdi_d   = sdi_o;
    case (state)
      IDLE: begin
        if (valid_i && ready_o) begin
          state_d = HIGH;
          shreg_d = frame_i;
          sdi_d   = frame_i[FRAME_WIDTH-1];
          bit_d   = BIT_FIRST;
          div_d   = '0;
          ready_d = 1'b0;
          sync_d  = 1'b0;
          sclk_d  = 1'b1;
        end
      end
      HIGH: begin
        if (div_cnt == DIV_LAST) begin
          state_d = LOW;
          div_d   = '0;
          sclk_d  = 1'b0;
        end else begin
          div_d = div_cnt + 1'b1;
        end
      end
      LOW: begin
        if (div_cnt == DIV_LAST) begin
          div_d  = '0;
          sclk_d = 1'b1;
          if (bit_cnt != '0) begin
            state_d = HIGH;
            bit_d   = bit_cnt - 1'b1;
            shreg_d = shreg << 1;
            sdi_d   = shreg[FRAME_WIDTH-2];
          end else begin
            // SYNC rises after the last low half-period so the DAC latches the word
            done_d  = 1'b1;
            sync_d  = 1'b1;
            sdi_d   = 1'b0;
            shreg_d = '0;
            gap_d   = '0;
            if (WAIT_CYCLES == 0) begin
              state_d = IDLE;
              ready_d = 1'b1;
            end else begin
              state_d = GAP;
            end
          end
        end else begin
          div_d = div_cnt + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_d = IDLE;
          ready_d = 1'b1;
          gap_d   = '0;
        end else begin
          gap_d = gap_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: three instances with different divider/gap settings; a
// cycle monitor decodes SDI on SCLK falling edges and checks frames against a queue.
module tb_dac_spi_tx;
  localparam int FW = 24;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic [FW-1:0] frame_i;
  logic          valid_i;
  logic [2:0]    ready_w, done_w, sync_w, sclk_w, sdi_w;

  always #5 clk = ~clk;

  // instance 0: CLK_DIV=2 WAIT=3, instance 1: CLK_DIV=1 WAIT=3, instance 2: CLK_DIV=1 WAIT=0
  for (genvar g = 0; g < 3; g++) begin : g_dut
    dac_spi_tx #(
      .FRAME_WIDTH(FW),
      .CLK_DIV    ((g == 0) ? 2 : 1),
      .WAIT_CYCLES((g == 2) ? 0 : 3)
    ) u_dut (
      .clk_i  (clk),
      .rst_ni (rst_ni),
      .frame_i(frame_i),
      .valid_i(valid_i),
      .ready_o(ready_w[g]),
      .done_o (done_w[g]),
      .sync_o (sync_w[g]),
      .sclk_o (sclk_w[g]),
      .sdi_o  (sdi_w[g])
    );
  end

  int   sel = 0;
  logic s_ready, s_done, s_sync, s_sclk, s_sdi;
  assign s_ready = ready_w[sel];
  assign s_done  = done_w[sel];
  assign s_sync  = sync_w[sel];
  assign s_sclk  = sclk_w[sel];
  assign s_sdi   = sdi_w[sel];

  int            vectors = 0;
  int            fails = 0;
  logic [FW-1:0] exp_q[$];
  logic          prev_sync = 1'b1;
  logic          prev_sclk = 1'b1;
  int            nbits = 0;
  int            low_len = 0;
  logic [FW-1:0] cap = '0;
  int            done_cnt = 0;
  bit            abort_ok = 1'b0;

  function automatic int cur_div();
    return (sel == 0) ? 2 : 1;
  endfunction

  function automatic int cur_wait();
    return (sel == 2) ? 0 : 3;
  endfunction

  // advance to the next falling clock edge and run the frame monitor there
  task automatic tick();
    logic [FW-1:0] exp;
    @(negedge clk);
    if (s_sync === 1'b0) begin
      low_len++;
      if (prev_sclk === 1'b1 && s_sclk === 1'b0) begin
        cap = {cap[FW-2:0], s_sdi};
        nbits++;
      end
    end
    if (s_done === 1'b1) done_cnt++;
    if (prev_sync === 1'b0 && s_sync === 1'b1) begin
      if (nbits == FW) begin
        vectors++;
        if (low_len !== 2 * cur_div() * FW) begin
          fails++;
          $display("FAIL sync_low_len: got %0d cycles, want %0d", low_len, 2 * cur_div() * FW);
        end
        vectors++;
        if (s_done !== 1'b1) begin
          fails++;
          $display("FAIL done_at_sync_rise: got %b, want 1", s_done);
        end
        vectors++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_frame: got %h, want no frame", cap);
        end else begin
          exp = exp_q.pop_front();
          if (cap !== exp) begin
            fails++;
            $display("FAIL frame_data: got %h, want %h", cap, exp);
          end
        end
      end else begin
        vectors++;
        if (!abort_ok) begin
          fails++;
          $display("FAIL partial_frame: got %0d bits, want %0d", nbits, FW);
        end else if (s_done !== 1'b0) begin
          fails++;
          $display("FAIL done_on_abort: got %b, want 0", s_done);
        end
      end
      nbits = 0;
      low_len = 0;
      cap = '0;
    end else if (s_done === 1'b1) begin
      vectors++;
      fails++;
      $display("FAIL spurious_done: got 1, want 0 (sync %b)", s_sync);
    end
    prev_sync = s_sync;
    prev_sclk = s_sclk;
  endtask

  task automatic reset_dut();
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    frame_i = '0;
    exp_q.delete();
    repeat (3) tick();
    nbits = 0;
    low_len = 0;
    cap = '0;
    rst_ni = 1'b1;
  endtask

  // called at a falling edge; returns right at the rising edge that accepts the frame
  task automatic drive_frame(input logic [FW-1:0] f, input bit push);
    bit ok;
    ok = 1'b0;
    frame_i = f;
    valid_i = 1'b1;
    if (push) exp_q.push_back(f);
    for (int n = 0; n < 200; n++) begin
      if (s_ready === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      tick();
    end
    vectors++;
    if (!ok) begin
      fails++;
      valid_i = 1'b0;
      $display("FAIL accept_timeout: got ready=%b, want 1 within 200 cycles", s_ready);
    end
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      tick();
      if (s_ready === 1'b1 && s_sync === 1'b1 && exp_q.size() == 0 && nbits == 0) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if (!ok) begin
      fails++;
      $display("FAIL idle_timeout: got ready=%b pending=%0d, want idle and 0", s_ready, exp_q.size());
    end
  endtask

  task automatic test_reset();
    sel = 0;
    reset_dut();
    for (int k = 0; k < 20; k++) begin
      tick();
      vectors++;
      if ({s_sync, s_sclk, s_sdi, s_ready, s_done} !== 5'b11010) begin
        fails++;
        $display("FAIL reset_idle cycle %0d: got sync/sclk/sdi/ready/done=%b, want 11010", k,
                 {s_sync, s_sclk, s_sdi, s_ready, s_done});
      end
    end
  endtask

  task automatic test_single();
    logic [2:0] exp;
    sel = 0;
    reset_dut();
    tick();
    drive_frame(24'hA5C3F0, 1'b1);
    for (int k = 0; k <= 100; k++) begin
      tick();
      if (k == 0) valid_i = 1'b0;
      exp = {k >= 96, k == 96, k >= 99};
      vectors++;
      if ({s_sync, s_done, s_ready} !== exp) begin
        fails++;
        $display("FAIL single_timing cycle %0d: got sync/done/ready=%b, want %b", k,
                 {s_sync, s_done, s_ready}, exp);
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL single_frame_seen: got %0d pending, want 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back(input int dut, input logic [FW-1:0] f0, input logic [FW-1:0] f1);
    int   hi, gap_seen, done0;
    logic ps, exp_r;
    sel = dut;
    reset_dut();
    tick();
    done0 = done_cnt;
    drive_frame(f0, 1'b1);
    tick();
    frame_i = f1;
    exp_q.push_back(f1);
    hi = 0;
    gap_seen = -1;
    ps = 1'b0;
    exp_r = (cur_wait() == 0);
    for (int n = 0; n < 400; n++) begin
      tick();
      if (s_done === 1'b1) begin
        vectors++;
        if (s_ready !== exp_r) begin
          fails++;
          $display("FAIL ready_at_done: got %b, want %b", s_ready, exp_r);
        end
      end
      if (ps === 1'b1 && s_sync === 1'b0) begin
        gap_seen = hi;
        valid_i = 1'b0;
        break;
      end
      if (s_sync === 1'b1) hi++;
      ps = s_sync;
    end
    valid_i = 1'b0;
    // the gap cycles plus the idle cycle in which the next frame is accepted
    vectors++;
    if (gap_seen != cur_wait() + 1) begin
      fails++;
      $display("FAIL b2b_sync_high: got %0d cycles, want %0d", gap_seen, cur_wait() + 1);
    end
    wait_idle(200);
    vectors++;
    if (done_cnt - done0 != 2) begin
      fails++;
      $display("FAIL b2b_done_count: got %0d, want 2", done_cnt - done0);
    end
  endtask

  task automatic test_abort();
    int   falls, done0;
    logic ps_sclk;
    sel = 0;
    reset_dut();
    tick();
    abort_ok = 1'b1;
    drive_frame(24'h123456, 1'b0);
    tick();
    valid_i = 1'b0;
    done0 = done_cnt;
    falls = 0;
    ps_sclk = 1'b1;
    for (int n = 0; n < 300; n++) begin
      tick();
      if (ps_sclk === 1'b1 && s_sclk === 1'b0 && s_sync === 1'b0) falls++;
      if (falls == 10) break;
      ps_sclk = s_sclk;
    end
    vectors++;
    if (falls != 10) begin
      fails++;
      $display("FAIL abort_falls: got %0d falling edges, want 10", falls);
    end
    rst_ni = 1'b0;
    tick();
    vectors++;
    if ({s_sync, s_sclk, s_sdi, s_ready, s_done} !== 5'b11010) begin
      fails++;
      $display("FAIL abort_outputs: got sync/sclk/sdi/ready/done=%b, want 11010",
               {s_sync, s_sclk, s_sdi, s_ready, s_done});
    end
    rst_ni = 1'b1;
    repeat (5) tick();
    abort_ok = 1'b0;
    vectors++;
    if (done_cnt != done0) begin
      fails++;
      $display("FAIL abort_done: got %0d pulses, want 0", done_cnt - done0);
    end
    drive_frame(24'h00ABCD, 1'b1);
    tick();
    valid_i = 1'b0;
    wait_idle(300);
  endtask

  task automatic test_stability();
    int rl;
    sel = 1;
    reset_dut();
    tick();
    drive_frame(24'h5A5A5A, 1'b1);
    rl = 0;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (s_ready === 1'b0) rl++;
      if (s_ready === 1'b1) break;
      if (s_sync === 1'b1) begin
        valid_i = 1'b0;
      end else begin
        frame_i = FW'($urandom);
        valid_i = ~valid_i;
      end
    end
    valid_i = 1'b0;
    vectors++;
    if (rl != 2 * FW + 3) begin
      fails++;
      $display("FAIL ready_low_len: got %0d cycles, want %0d", rl, 2 * FW + 3);
    end
    wait_idle(100);
    repeat (5) tick();
  endtask

  initial begin
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    frame_i = '0;
    test_reset();
    test_single();
    test_back_to_back(1, 24'h000001, 24'hFFFFFF);
    test_back_to_back(2, 24'hC0FFEE, 24'h3C3C3C);
    test_abort();
    test_stability();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish before 500000 ns");
    $fatal(1);
  end

endmodule
